// File: rtl/exe_issue_ctrl.sv
// Scoreboard-based issue controller: RAW/WAW/structural hazard detection, a
// sequencer for the shared multi-cycle unit, and a saturating stall counter.
module exe_issue_ctrl #(
  parameter int NREG        = 32,
  parameter int RADDR_WIDTH = 5,
  parameter int MC_LAT      = 4,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   issue_valid_i,
  input  logic [RADDR_WIDTH-1:0] rs1_i,
  input  logic [RADDR_WIDTH-1:0] rs2_i,
  input  logic                   rs1_use_i,
  input  logic                   rs2_use_i,
  input  logic [RADDR_WIDTH-1:0] rd_i,
  input  logic                   we_i,
  input  logic                   mc_i,
  output logic                   issue_ready_o,
  output logic                   exe_start_o,
  output logic                   mc_start_o,
  output logic                   mc_busy_o,
  output logic                   mc_done_o,
  input  logic                   wb_we_i,
  input  logic [RADDR_WIDTH-1:0] wb_waddr_i,
  input  logic                   flush_i,
  output logic [CNT_WIDTH-1:0]   stall_cnt_o
);

  typedef enum logic [0:0] {IDLE, BUSY} state_t;

  state_t          state;
  logic [3:0]      cnt;
  logic [NREG-1:0] sb;
  logic [NREG-1:0] clr;
  logic [NREG-1:0] eff;
  logic [NREG-1:0] sb_next;
  logic            raw;
  logic            waw;
  logic            hz_struct;
  logic            fire;
  logic            stall;

  // A register retired this cycle is bypassed, so it is not a hazard.
  always_comb begin
    clr = '0;
    if (wb_we_i) clr[wb_waddr_i] = 1'b1;
    eff    = sb & ~clr;
    eff[0] = 1'b0;
  end

  always_comb begin
    raw           = (rs1_use_i & eff[rs1_i]) | (rs2_use_i & eff[rs2_i]);
    waw           = we_i & eff[rd_i];
    hz_struct     = mc_i & (state == BUSY);
    issue_ready_o = !rst_i && !flush_i && !raw && !waw && !hz_struct;
    fire          = issue_valid_i & issue_ready_o;
    exe_start_o   = fire & !mc_i;
    mc_start_o    = fire & mc_i;
    stall         = issue_valid_i & !issue_ready_o & !flush_i;
  end

  // Set is applied after clear so a new producer owns a register retired this cycle.
  always_comb begin
    sb_next = sb & ~clr;
    if (fire && we_i && (rd_i != '0)) sb_next[rd_i] = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sb          <= '0;
      state       <= IDLE;
      cnt         <= '0;
      mc_busy_o   <= 1'b0;
      mc_done_o   <= 1'b0;
      stall_cnt_o <= '0;
    end else begin
      if (stall && (stall_cnt_o != '1)) stall_cnt_o <= stall_cnt_o + CNT_WIDTH'(1);

      if (flush_i) begin
        sb        <= '0;
        state     <= IDLE;
        cnt       <= '0;
        mc_busy_o <= 1'b0;
        mc_done_o <= 1'b0;
      end else begin
        sb <= sb_next;
        unique case (state)
          IDLE: begin
            if (mc_start_o) begin
              state     <= BUSY;
              cnt       <= 4'(MC_LAT - 1);
              mc_busy_o <= 1'b1;
              mc_done_o <= (MC_LAT == 2);
            end else begin
              mc_done_o <= 1'b0;
            end
          end
          BUSY: begin
            // done is raised on the edge where cnt reaches 1 so it marks the last busy cycle
            if (cnt > 4'd1) begin
              cnt       <= cnt - 4'd1;
              mc_done_o <= (cnt == 4'd2);
            end else begin
              state     <= IDLE;
              cnt       <= '0;
              mc_busy_o <= 1'b0;
              mc_done_o <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_exe_issue_ctrl.sv
// Directed table-driven bench for exe_issue_ctrl, plus hand-written
// sequences for counter saturation and reset recovery.
module tb_exe_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid;
  logic [4:0]  rs1, rs2, rd, wb_waddr;
  logic        rs1_use, rs2_use, we, mc, wb_we, flush;
  logic        issue_ready, exe_start, mc_start, mc_busy, mc_done;
  logic [15:0] stall_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  exe_issue_ctrl #(.NREG(32), .RADDR_WIDTH(5), .MC_LAT(4), .CNT_WIDTH(16)) dut (
    .clk_i(clk), .rst_i(rst), .issue_valid_i(issue_valid),
    .rs1_i(rs1), .rs2_i(rs2), .rs1_use_i(rs1_use), .rs2_use_i(rs2_use),
    .rd_i(rd), .we_i(we), .mc_i(mc),
    .issue_ready_o(issue_ready), .exe_start_o(exe_start), .mc_start_o(mc_start),
    .mc_busy_o(mc_busy), .mc_done_o(mc_done),
    .wb_we_i(wb_we), .wb_waddr_i(wb_waddr), .flush_i(flush),
    .stall_cnt_o(stall_cnt)
  );

  typedef struct {
    logic rst, valid;
    logic [4:0] rs1; logic u1;
    logic [4:0] rs2; logic u2;
    logic [4:0] rd; logic we, mc;
    logic wbwe; logic [4:0] wba;
    logic flush;
    logic e_rdy, e_exe, e_mc, e_busy, e_done;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(int r, int v, int a1, int u1, int a2, int u2, int d, int w,
                              int m, int wbw, int wba, int f,
                              int rdy, int ex, int ms, int bz, int dn, int cn);
    vec_t t;
    t.rst = 1'(r); t.valid = 1'(v); t.rs1 = 5'(a1); t.u1 = 1'(u1);
    t.rs2 = 5'(a2); t.u2 = 1'(u2); t.rd = 5'(d); t.we = 1'(w); t.mc = 1'(m);
    t.wbwe = 1'(wbw); t.wba = 5'(wba); t.flush = 1'(f);
    t.e_rdy = 1'(rdy); t.e_exe = 1'(ex); t.e_mc = 1'(ms);
    t.e_busy = 1'(bz); t.e_done = 1'(dn); t.e_cnt = 16'(cn);
    return t;
  endfunction

  task automatic chk(input string name, input int idx, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s [%0d]: got %0d expected %0d", name, idx, act, exp);
    end
  endtask

  task automatic drive(input vec_t t);
    rst = t.rst; issue_valid = t.valid; rs1 = t.rs1; rs1_use = t.u1;
    rs2 = t.rs2; rs2_use = t.u2; rd = t.rd; we = t.we; mc = t.mc;
    wb_we = t.wbwe; wb_waddr = t.wba; flush = t.flush;
  endtask

  initial begin
    //            rst v rs1 u1 rs2 u2 rd we mc wbw wba fl | rdy exe mcs bsy dn cnt
    vecs.push_back(mk(1, 1, 1, 1, 0, 0, 5, 1, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 1, 0, 0, 5, 1, 0, 0, 0, 0,   1, 1, 0, 0, 0, 0));  // addi rd=5
    vecs.push_back(mk(0, 1, 5, 1, 0, 0, 6, 1, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0));  // RAW on 5
    vecs.push_back(mk(0, 1, 5, 1, 0, 0, 6, 1, 0, 0, 0, 0,   0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 1, 5, 1, 0, 0, 6, 1, 0, 1, 5, 0,   1, 1, 0, 0, 0, 2));  // wb bypass
    vecs.push_back(mk(0, 1, 5, 1, 0, 0, 8, 1, 0, 0, 0, 0,   1, 1, 0, 0, 0, 2));  // sb[5] cleared
    vecs.push_back(mk(0, 1, 6, 1, 0, 0, 0, 1, 0, 1, 6, 0,   1, 1, 0, 0, 0, 2));  // rd=0
    vecs.push_back(mk(0, 1, 0, 1, 0, 1, 0, 1, 0, 0, 0, 0,   1, 1, 0, 0, 0, 2));  // x0 reads
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 9, 1, 0, 1, 9, 0,   1, 1, 0, 0, 0, 2));  // set+clear 9
    vecs.push_back(mk(0, 1, 0, 0, 9, 1,10, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 2));  // set won
    vecs.push_back(mk(0, 0, 0, 0, 9, 1, 0, 0, 0, 1, 9, 0,   1, 0, 0, 0, 0, 3));  // idle, ready anyway
    vecs.push_back(mk(0, 1, 8, 1, 0, 0, 8, 1, 0, 1, 8, 0,   1, 1, 0, 0, 0, 3));
    vecs.push_back(mk(0, 1, 8, 1, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 3));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 8, 0,   1, 0, 0, 0, 0, 4));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0,11, 1, 0, 0, 0, 0,   1, 1, 0, 0, 0, 4));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0,11, 1, 0, 0, 0, 0,   0, 0, 0, 0, 0, 4));  // WAW
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1,11, 0,   1, 0, 0, 0, 0, 5));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 7, 1, 1, 0, 0, 0,   1, 0, 1, 0, 0, 5));  // mc T
    vecs.push_back(mk(0, 1, 1, 1, 0, 0, 3, 1, 0, 0, 0, 0,   1, 1, 0, 1, 0, 5));  // addi T+1
    vecs.push_back(mk(0, 1, 0, 0, 0, 0,12, 1, 1, 0, 0, 0,   0, 0, 0, 1, 0, 5));  // mc T+2 stalls
    vecs.push_back(mk(0, 1, 0, 0, 0, 0,12, 1, 1, 0, 0, 0,   0, 0, 0, 1, 1, 6));  // T+3 done
    vecs.push_back(mk(0, 1, 0, 0, 0, 0,12, 1, 1, 0, 0, 0,   1, 0, 1, 0, 0, 7));  // T+4 issues
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 7, 0,   1, 0, 0, 1, 0, 7));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 0,   1, 0, 0, 1, 0, 7));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1,12, 0,   1, 0, 0, 1, 1, 7));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 7));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 7, 1, 1, 0, 0, 0,   1, 0, 1, 0, 0, 7));  // mc T
    vecs.push_back(mk(0, 1, 0, 0, 0, 0,20, 1, 0, 0, 0, 0,   1, 1, 0, 1, 0, 7));
    vecs.push_back(mk(0, 1, 7, 1, 0, 0, 0, 0, 0, 0, 0, 1,   0, 0, 0, 1, 0, 7));  // flush T+2
    vecs.push_back(mk(0, 1, 7, 1,20, 1, 7, 1, 0, 0, 0, 0,   1, 1, 0, 0, 0, 7));  // sb cleared
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 7));  // no done
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 7));

    drive(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    repeat (2) @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      drive(vecs[i]);
      @(negedge clk);
      chk("ready",     i, int'(issue_ready), int'(vecs[i].e_rdy));
      chk("exe_start", i, int'(exe_start),   int'(vecs[i].e_exe));
      chk("mc_start",  i, int'(mc_start),    int'(vecs[i].e_mc));
      chk("mc_busy",   i, int'(mc_busy),     int'(vecs[i].e_busy));
      chk("mc_done",   i, int'(mc_done),     int'(vecs[i].e_done));
      chk("stall_cnt", i, int'(stall_cnt),   int'(vecs[i].e_cnt));
      @(posedge clk);
      #1;
    end

    // sb[7] is pending; hold a RAW stall long enough to saturate the counter.
    drive(mk(0, 1, 7, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    repeat (70000) @(posedge clk);
    #1;
    @(negedge clk);
    chk("sat_ready", 0, int'(issue_ready), 0);
    chk("sat_cnt",   0, int'(stall_cnt),   16'hFFFF);
    @(posedge clk);
    #1;
    chk("sat_hold",  0, int'(stall_cnt),   16'hFFFF);

    rst = 1'b1;
    @(negedge clk);
    chk("rst_ready", 0, int'(issue_ready), 0);
    chk("rst_exe",   0, int'(exe_start),   0);
    @(posedge clk);
    #1;
    chk("rst_cnt",   0, int'(stall_cnt),   0);
    chk("rst_busy",  0, int'(mc_busy),     0);

    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 0, int'(issue_ready), 1);
    chk("post_rst_exe",   0, int'(exe_start),   1);
    @(posedge clk);
    #1;
    chk("post_rst_cnt",   0, int'(stall_cnt),   0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/exe_issue_ctrl.md
Name: exe_issue_ctrl

Overview:
- Scoreboard-based issue controller between the id_exe register and the exe stage.
- Tracks pending register writes and stalls decode on RAW/WAW hazards.
- Sequences a shared multi-cycle execution unit (iterative shifter/multiplier) through an IDLE/BUSY state machine.
- Counts stall cycles for performance monitoring.

Parameters:
- NREG, 32, number of architectural registers; x0 is never tracked.
- RADDR_WIDTH, 5, register address width; must satisfy 2^RADDR_WIDTH = NREG.
- MC_LAT, 4, multi-cycle unit latency in cycles; legal range 2..15.
- CNT_WIDTH, 16, width of the saturating stall counter.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- issue_valid_i  in  1  decode presents an instruction.
- rs1_i, rs2_i  in  RADDR_WIDTH  source register addresses.
- rs1_use_i, rs2_use_i  in  1  the corresponding source is actually read.
- rd_i  in  RADDR_WIDTH  destination register.
- we_i  in  1  the instruction writes rd.
- mc_i  in  1  the instruction needs the multi-cycle unit.
- issue_ready_o  out  1  instruction may issue this cycle (combinational).
- exe_start_o  out  1  single-cycle op issued (combinational, = fire & !mc_i).
- mc_start_o  out  1  multi-cycle op issued (combinational, = fire & mc_i).
- mc_busy_o  out  1  multi-cycle unit occupied (registered).
- mc_done_o  out  1  one-cycle pulse on the unit's final cycle (registered).
- wb_we_i  in  1  writeback retires a write.
- wb_waddr_i  in  RADDR_WIDTH  register retired by writeback.
- flush_i  in  1  kill all in-flight work.
- stall_cnt_o  out  CNT_WIDTH  saturating count of stalled cycles.

Behaviour:
- Reset (rst_i=1 at a clock edge):
  - scoreboard sb[NREG-1:0]=0; FSM=IDLE; mc_busy_o=0; mc_done_o=0; stall_cnt_o=0.
  - While rst_i=1, issue_ready_o=0, exe_start_o=0, mc_start_o=0.
- Clear mask and effective scoreboard:
  - clr = one-hot(wb_waddr_i) when wb_we_i, else 0.
  - eff = sb & ~clr. This gives same-cycle bypass: a register retired this cycle is not a hazard.
- Hazard terms:
  - raw = (rs1_use_i & eff[rs1_i]) | (rs2_use_i & eff[rs2_i]).
  - waw = we_i & eff[rd_i].
  - struct = mc_i & (state==BUSY).
  - eff[0] is forced 0, so x0 never causes a hazard.
- issue_ready_o = !rst_i & !flush_i & !raw & !waw & !struct.
  - Ready is computed regardless of issue_valid_i.
  - fire = issue_valid_i & issue_ready_o.
- Scoreboard next-state, by priority:
  1. flush_i: sb <= 0.
  2. Otherwise sb <= (sb & ~clr), then bit rd_i set if fire & we_i & rd_i!=0.
  - When the same register is set and cleared in one cycle, set wins (the new producer owns it).
- Multi-cycle FSM (counter cnt, 4 bits):
  - IDLE: on mc_start_o, go to BUSY with cnt=MC_LAT-1 and mc_busy_o=1 from the next cycle.
  - BUSY, cnt>1: cnt decrements.
  - BUSY, cnt==1: mc_done_o=1 for the following cycle, then return to IDLE.
  - mc_busy_o is high for exactly MC_LAT-1 cycles after the start cycle. The done cycle is the last busy cycle.
  - A new mc op may issue in the cycle after mc_done_o is asserted.
  - Single-cycle ops issue freely while BUSY, subject to hazards.
- flush_i, with priority below reset:
  - FSM goes to IDLE; mc_busy_o and mc_done_o go to 0 next cycle; no mc_done_o is generated.
  - issue_ready_o=0 in the flush cycle. stall_cnt_o does not increment in the flush cycle.
- Stall counter:
  - Increments when issue_valid_i & !issue_ready_o & !flush_i.
  - Saturates at all-ones (no wrap).
- Writeback to a register with no pending bit is harmless; no error is flagged.

Test Plan:
- Reset, then valid addi rs1=1, rd=5, we=1 → ready=1, exe_start_o=1, sb[5]=1 next cycle, stall_cnt=0.
- sb[5]=1, next instruction rs1=5, rs1_use=1 → ready=0 and stall_cnt increments each cycle. Then wb_we=1, waddr=5 → ready=1 in that same cycle; sb[5]=0 after the edge unless the instruction itself writes rd=5.
- rd=0, we=1 → sb unchanged. rs1=0, rs1_use=1 with any sb → no stall. Issue with rd=9 while wb retires 9 in the same cycle → sb[9]=1 afterward.
- MC_LAT=4, mc op rd=7 at cycle T:
  - mc_start_o=1 at T; mc_busy_o=1 for T+1..T+3; mc_done_o=1 at T+3.
  - A second mc op presented at T+1 stalls until T+4.
  - An independent addi rd=3 issues at T+1.
- Flush at T+2 during BUSY → sb=0, mc_busy_o=0 at T+3, no mc_done_o, ready=0 at T+2, stall_cnt unchanged at T+2.
- Force a permanent RAW stall for 70000 cycles with CNT_WIDTH=16 → stall_cnt_o holds 0xFFFF. Then rst_i → stall_cnt_o=0 and ready=0 during reset.
